// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: state encoding,
// default geometry and the flattened-port slice helper.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_DEPTH  = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Low bit of port idx inside a vector of w-bit fields packed side by side
    function automatic int unsigned slice_lo(int unsigned idx, int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Operand-fetch / writeback bus of the register file; the file itself is the slave.
interface register_file_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1
);
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     init_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, init_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, init_done
    );
endinterface

// File: rtl/rf_read_port.sv
// One read port: range/zero check, priority bypass over the write ports,
// and the enable-gated output register.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        arr_data,
    input  logic [NUM_WR-1:0]        wr_ok,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data
);
    logic [DATA_W-1:0] sel_c;

    // Later write ports override earlier ones; range/zero checks override all
    always_comb begin
        sel_c = arr_data;
        if (BYPASS != 0) begin
            for (int k = 0; k < int'(NUM_WR); k++) begin
                if (wr_ok[k] && (wr_addr[slice_lo(k, ADDR_W) +: ADDR_W] == rd_addr)) begin
                    sel_c = wr_data[slice_lo(k, DATA_W) +: DATA_W];
                end
            end
        end
        if ((32'(rd_addr) >= DEPTH) || ((ZERO_REG != 0) && (rd_addr == '0))) begin
            sel_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= sel_c;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file for DECODE: clear sweep after reset,
// write arbitration, and NUM_RD registered read ports.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_mp_if.slave  bus
);
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_WR-1:0] wr_ok_c;
    logic              run_c;

    assign run_c         = (state_q == RF_RUN);
    assign bus.init_done = init_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RF_CLEAR;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    // Clear sweep: one entry per cycle, last entry hands over to RUN
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        if (state_q == RF_CLEAR) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (32'(clr_ptr_q) == DEPTH - 1) begin
                state_d     = RF_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_WR); k++) begin : g_wr_ok
        logic [ADDR_W-1:0] addr;
        assign addr       = bus.wr_addr[slice_lo(k, ADDR_W) +: ADDR_W];
        assign wr_ok_c[k] = run_c && bus.wr_en[k] && (32'(addr) < DEPTH)
                            && !((ZERO_REG != 0) && (addr == '0));
    end

    // Ascending port order lets the highest index win a same-address collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_CLEAR) begin
                mem[clr_ptr_q] <= '0;
            end else begin
                for (int k = 0; k < int'(NUM_WR); k++) begin
                    if (wr_ok_c[k]) begin
                        mem[bus.wr_addr[slice_lo(k, ADDR_W) +: ADDR_W]]
                            <= bus.wr_data[slice_lo(k, DATA_W) +: DATA_W];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rdata;
        assign raddr = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
        assign bus.rd_data[slice_lo(i, DATA_W) +: DATA_W] = rdata;

        rf_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .run      (run_c),
            .rd_en    (bus.rd_en[i]),
            .rd_addr  (raddr),
            .arr_data (mem[raddr]),
            .wr_ok    (wr_ok_c),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rd_data  (rdata)
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: dut_a = 32 entries, 2 write ports, bypass on;
// dut_b = 24 entries, 1 write port, bypass off. Both share clk and rst.
module tb_register_file_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) ifa ();
    register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1)) ifb ();

    register_file_mp #(
        .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    register_file_mp #(
        .DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_en = '0; ifa.rd_addr = '0;
        ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_en = '0; ifb.rd_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_total++;
        if (ifa.init_done !== 1'b0 || ifa.rd_data !== 64'h0)
            $display("FAIL reset_a: init_done=%b rd_data=%h, want 0 / 0", ifa.init_done, ifa.rd_data);
        else n_pass++;
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            n_total++;
            if (ifa.init_done !== (i == 32))
                $display("FAIL sweep_a edge %0d: init_done=%b want %b", i, ifa.init_done, (i == 32));
            else n_pass++;
            n_total++;
            if (ifb.init_done !== (i >= 24))
                $display("FAIL sweep_b edge %0d: init_done=%b want %b", i, ifb.init_done, (i >= 24));
            else n_pass++;
        end
        for (int a = 0; a < 32; a += 2) begin
            ifa.rd_en = 2'b11; ifa.rd_addr = {5'(a + 1), 5'(a)};
            ifb.rd_en = 2'b11; ifb.rd_addr = {5'(a + 1), 5'(a)};
            tick();
            n_total++;
            if (ifa.rd_data !== 64'h0 || ifb.rd_data !== 64'h0)
                $display("FAIL cleared r%0d/r%0d: a=%h b=%h want 0", a, a + 1, ifa.rd_data, ifb.rd_data);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_basic();
        ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5}; ifa.wr_data = {32'h0, 32'hDEADBEEF};
        tick();
        ifa.wr_en = 2'b10; ifa.wr_addr = {5'd6, 5'd0}; ifa.wr_data = {32'hCAFEF00D, 32'h0};
        ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd5};
        tick();
        n_total++;
        if (ifa.rd_data[31:0] !== 32'hDEADBEEF)
            $display("FAIL basic_r5: got %h want deadbeef", ifa.rd_data[31:0]);
        else n_pass++;
        ifa.wr_en = 2'b00; ifa.rd_en = 2'b10; ifa.rd_addr = {5'd6, 5'd0};
        tick();
        n_total++;
        if (ifa.rd_data !== 64'hCAFEF00D_DEADBEEF)
            $display("FAIL basic_r6_hold: got %h want cafef00ddeadbeef", ifa.rd_data);
        else n_pass++;
        idle();
    endtask

    task automatic test_bypass();
        ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd7}; ifa.wr_data = {32'h0, 32'h12345678};
        ifa.rd_en = 2'b11; ifa.rd_addr = {5'd7, 5'd7};
        ifb.wr_en = 1'b1;  ifb.wr_addr = 5'd7; ifb.wr_data = 32'h12345678;
        ifb.rd_en = 2'b11; ifb.rd_addr = {5'd7, 5'd7};
        tick();
        n_total++;
        if (ifa.rd_data !== 64'h12345678_12345678)
            $display("FAIL bypass_on: got %h want 1234567812345678", ifa.rd_data);
        else n_pass++;
        n_total++;
        if (ifb.rd_data !== 64'h0)
            $display("FAIL bypass_off: got %h want 0", ifb.rd_data);
        else n_pass++;
        ifb.wr_en = 1'b0;
        tick();
        n_total++;
        if (ifb.rd_data !== 64'h12345678_12345678)
            $display("FAIL bypass_off_next: got %h want 1234567812345678", ifb.rd_data);
        else n_pass++;
        idle();
    endtask

    task automatic test_zero_and_priority();
        ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd0}; ifa.wr_data = {32'h0, 32'hFFFFFFFF};
        ifa.rd_en = 2'b10; ifa.rd_addr = {5'd0, 5'd0};
        tick();
        n_total++;
        if (ifa.rd_data[63:32] !== 32'h0)
            $display("FAIL zero_bypass: got %h want 0", ifa.rd_data[63:32]);
        else n_pass++;
        ifa.wr_en = 2'b11; ifa.wr_addr = {5'd3, 5'd3}; ifa.wr_data = {32'h0000BBBB, 32'h0000AAAA};
        ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd0};
        tick();
        n_total++;
        if (ifa.rd_data[31:0] !== 32'h0)
            $display("FAIL zero_read: got %h want 0", ifa.rd_data[31:0]);
        else n_pass++;
        ifa.wr_en = 2'b11; ifa.wr_addr = {5'd4, 5'd4}; ifa.wr_data = {32'h00002222, 32'h00001111};
        ifa.rd_en = 2'b11; ifa.rd_addr = {5'd4, 5'd3};
        tick();
        n_total++;
        if (ifa.rd_data !== 64'h00002222_0000BBBB)
            $display("FAIL dual_write: got %h want 000022220000bbbb", ifa.rd_data);
        else n_pass++;
        ifa.wr_en = 2'b00; ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd4};
        tick();
        n_total++;
        if (ifa.rd_data[31:0] !== 32'h00002222)
            $display("FAIL dual_write_r4: got %h want 00002222", ifa.rd_data[31:0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_stall_hold();
        ifb.wr_en = 1'b1; ifb.wr_addr = 5'd9; ifb.wr_data = 32'h55;
        tick();
        ifb.wr_en = 1'b0; ifb.rd_en = 2'b01; ifb.rd_addr = {5'd0, 5'd9};
        tick();
        n_total++;
        if (ifb.rd_data[31:0] !== 32'h55)
            $display("FAIL stall_pre: got %h want 55", ifb.rd_data[31:0]);
        else n_pass++;
        ifb.rd_en = 2'b00; ifb.wr_en = 1'b1; ifb.wr_data = 32'h66;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (ifb.rd_data[31:0] !== 32'h55)
                $display("FAIL stall_hold cyc %0d: got %h want 55", c, ifb.rd_data[31:0]);
            else n_pass++;
        end
        ifb.wr_en = 1'b0; ifb.rd_en = 2'b01;
        tick();
        n_total++;
        if (ifb.rd_data[31:0] !== 32'h66)
            $display("FAIL stall_release: got %h want 66", ifb.rd_data[31:0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_val;
        ifb.wr_en = 1'b1; ifb.wr_addr = 5'd30; ifb.wr_data = 32'h77;
        ifb.rd_en = 2'b01; ifb.rd_addr = {5'd0, 5'd30};
        tick();
        n_total++;
        if (ifb.rd_data[31:0] !== 32'h0)
            $display("FAIL oor_read: got %h want 0", ifb.rd_data[31:0]);
        else n_pass++;
        ifb.wr_en = 1'b0;
        for (int a = 0; a < 24; a++) begin
            ifb.rd_en = 2'b01; ifb.rd_addr = {5'd0, 5'(a)};
            tick();
            exp_val = (a == 7) ? 32'h12345678 : (a == 9) ? 32'h66 : 32'h0;
            n_total++;
            if (ifb.rd_data[31:0] !== exp_val)
                $display("FAIL oor_no_alias r%0d: got %h want %h", a, ifb.rd_data[31:0], exp_val);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        ifa.wr_en = 2'b11; ifa.wr_addr = {5'd20, 5'd10}; ifa.wr_data = {32'h00002020, 32'h00001234};
        ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd5};
        tick();
        n_total++;
        if (ifa.rd_data[31:0] !== 32'hDEADBEEF)
            $display("FAIL pre_reset_read: got %h want deadbeef", ifa.rd_data[31:0]);
        else n_pass++;
        idle();
        rst = 1'b1;
        tick();
        n_total++;
        if (ifa.init_done !== 1'b0 || ifa.rd_data !== 64'h0)
            $display("FAIL run_reset: init_done=%b rd_data=%h want 0 / 0", ifa.init_done, ifa.rd_data);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_total++;
        if (ifa.init_done !== 1'b0)
            $display("FAIL mid_sweep: init_done=%b want 0", ifa.init_done);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.rd_en = 2'b11; ifa.rd_addr = {5'd20, 5'd10};
        for (int i = 1; i <= 32; i++) begin
            tick();
            n_total++;
            if (ifa.init_done !== (i == 32))
                $display("FAIL resweep edge %0d: init_done=%b want %b", i, ifa.init_done, (i == 32));
            else n_pass++;
            if (i == 16) begin
                n_total++;
                if (ifa.rd_data !== 64'h0)
                    $display("FAIL read_in_clear: got %h want 0", ifa.rd_data);
                else n_pass++;
            end
        end
        tick();
        n_total++;
        if (ifa.rd_data !== 64'h0)
            $display("FAIL resweep_cleared: got %h want 0", ifa.rd_data);
        else n_pass++;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_bypass();
        test_zero_and_priority();
        test_stall_hold();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
